// File: rtl/aes_encipher_block_pkg.sv
//------------------------------------------------------------------------------
// aes_encipher_block_pkg
// Shared constants, FSM/update encodings and GF(2^8) helpers for the AES
// encipher datapath. The state layout is {w0,w1,w2,w3} and byte 0 of a word
// is bits [31:24].
//------------------------------------------------------------------------------
package aes_encipher_block_pkg;

    localparam int unsigned BLOCK_W     = 128;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ROUND_W     = 4;
    localparam int unsigned SWORD_W     = 2;

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    localparam logic KEYLEN_AES128 = 1'b0;
    localparam logic KEYLEN_AES256 = 1'b1;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_INIT = 2'd1,
        FSM_SBOX = 2'd2,
        FSM_MAIN = 2'd3
    } fsm_t;

    // What the state registers load this cycle.
    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_INIT  = 3'd1,
        UPD_SBOX  = 3'd2,
        UPD_MAIN  = 3'd3,
        UPD_FINAL = 3'd4
    } update_t;

    // Multiply by x in GF(2^8) with polynomial 0x11b.
    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    // MixColumns applied to a single column word.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] m0, m1, m2, m3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        m0 = gm2(b0) ^ gm3(b1) ^ b2      ^ b3;
        m1 = b0      ^ gm2(b1) ^ gm3(b2) ^ b3;
        m2 = b0      ^ b1      ^ gm2(b2) ^ gm3(b3);
        m3 = gm3(b0) ^ b1      ^ b2      ^ gm2(b3);
        return {m0, m1, m2, m3};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] data);
        return {mixw(data[127:96]), mixw(data[95:64]),
                mixw(data[63:32]),  mixw(data[31:0])};
    endfunction

    // Row r (byte r of every word) rotates left by r columns.
    function automatic logic [127:0] shiftrows(input logic [127:0] data);
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] s0, s1, s2, s3;
        w0 = data[127:96];
        w1 = data[95:64];
        w2 = data[63:32];
        w3 = data[31:0];
        s0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
        s1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
        s2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
        s3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
        return {s0, s1, s2, s3};
    endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
//------------------------------------------------------------------------------
// aes_mixcolumns
// Combinational 128-bit AES MixColumns over four independent column words.
// Ports:
//   data   in  128  state {w0,w1,w2,w3}
//   mixed  out 128  MixColumns(data)
//------------------------------------------------------------------------------
module aes_mixcolumns
    import aes_encipher_block_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    output logic [BLOCK_W-1:0] mixed
);

    assign mixed = mixcolumns(data);

endmodule

// File: rtl/aes_encipher_block.sv
//------------------------------------------------------------------------------
// aes_encipher_block
// Iterative AES encipher: InitRound, Nr-1 main rounds and the final round on
// one 128-bit block. SubBytes runs one word per cycle through an external
// S-box shared with key expansion; round keys come from an external key
// memory addressed by `round`.
// Ports:
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous active-high reset
//   next       in   1    start an encipher (sampled only when idle)
//   keylen     in   1    0 = AES-128, 1 = AES-256
//   round      out  4    current round index / key memory address
//   round_key  in   128  round key for `round` (same cycle)
//   sboxw      out  32   word presented to the shared S-box
//   new_sboxw  in   32   S-box result for sboxw (same cycle)
//   block      in   128  plaintext
//   new_block  out  128  state {w0,w1,w2,w3}; ciphertext once ready
//   ready      out  1    1 = idle/done, 0 = busy
//------------------------------------------------------------------------------
module aes_encipher_block
    import aes_encipher_block_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 next,
    input  logic                 keylen,
    output logic [ROUND_W-1:0]   round,
    input  logic [BLOCK_W-1:0]   round_key,
    output logic [WORD_W-1:0]    sboxw,
    input  logic [WORD_W-1:0]    new_sboxw,
    input  logic [BLOCK_W-1:0]   block,
    output logic [BLOCK_W-1:0]   new_block,
    output logic                 ready
);

    logic [WORD_W-1:0]  w_reg [4];
    logic [WORD_W-1:0]  w_new [4];
    logic [3:0]         w_we;

    logic [SWORD_W-1:0] sword_ctr_reg, sword_ctr_new;
    logic [ROUND_W-1:0] round_ctr_reg, round_ctr_new;
    logic               ready_reg, ready_new;
    fsm_t               fsm_reg, fsm_new;
    update_t            update_type;

    logic [ROUND_W-1:0] num_rounds;
    logic [BLOCK_W-1:0] state;
    logic [BLOCK_W-1:0] sr_state;
    logic [BLOCK_W-1:0] mc_state;

    assign state      = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign sr_state   = shiftrows(state);
    assign num_rounds = (keylen == KEYLEN_AES256) ? AES256_ROUNDS : AES128_ROUNDS;

    assign round     = round_ctr_reg;
    assign new_block = state;
    assign ready     = ready_reg;

    aes_mixcolumns u_mixcolumns (
        .data  (sr_state),
        .mixed (mc_state)
    );

    // State, counters, ready flag and FSM register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                w_reg[i] <= '0;
            end
            sword_ctr_reg <= '0;
            round_ctr_reg <= '0;
            ready_reg     <= 1'b1;
            fsm_reg       <= FSM_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) begin
                    w_reg[i] <= w_new[i];
                end
            end
            sword_ctr_reg <= sword_ctr_new;
            round_ctr_reg <= round_ctr_new;
            ready_reg     <= ready_new;
            fsm_reg       <= fsm_new;
        end
    end

    // Next-state, counter and update-type control.
    always_comb begin
        fsm_new       = fsm_reg;
        ready_new     = ready_reg;
        round_ctr_new = round_ctr_reg;
        sword_ctr_new = sword_ctr_reg;
        update_type   = UPD_NONE;

        case (fsm_reg)
            FSM_IDLE: begin
                if (next) begin
                    round_ctr_new = '0;
                    ready_new     = 1'b0;
                    fsm_new       = FSM_INIT;
                end
            end

            FSM_INIT: begin
                update_type   = UPD_INIT;
                round_ctr_new = ROUND_W'(round_ctr_reg + 4'd1);
                sword_ctr_new = '0;
                fsm_new       = FSM_SBOX;
            end

            FSM_SBOX: begin
                update_type   = UPD_SBOX;
                sword_ctr_new = SWORD_W'(sword_ctr_reg + 2'd1);
                if (sword_ctr_reg == 2'd3) begin
                    fsm_new = FSM_MAIN;
                end
            end

            FSM_MAIN: begin
                // Nr is re-read every round, so a keylen change mid-op still
                // terminates once round_ctr reaches (or wraps to) Nr.
                if (round_ctr_reg < num_rounds) begin
                    update_type   = UPD_MAIN;
                    round_ctr_new = ROUND_W'(round_ctr_reg + 4'd1);
                    sword_ctr_new = '0;
                    fsm_new       = FSM_SBOX;
                end else begin
                    update_type = UPD_FINAL;
                    ready_new   = 1'b1;
                    fsm_new     = FSM_IDLE;
                end
            end

            default: begin
                fsm_new = FSM_IDLE;
            end
        endcase
    end

    // State word update values and per-word write enables.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_new[i] = w_reg[i];
        end
        w_we  = 4'b0000;
        sboxw = '0;

        if (fsm_reg == FSM_SBOX) begin
            sboxw = w_reg[sword_ctr_reg];
        end

        case (update_type)
            UPD_INIT: begin
                w_we     = 4'b1111;
                w_new[0] = block[127:96] ^ round_key[127:96];
                w_new[1] = block[95:64]  ^ round_key[95:64];
                w_new[2] = block[63:32]  ^ round_key[63:32];
                w_new[3] = block[31:0]   ^ round_key[31:0];
            end

            UPD_SBOX: begin
                w_we[sword_ctr_reg]  = 1'b1;
                w_new[sword_ctr_reg] = new_sboxw;
            end

            UPD_MAIN: begin
                w_we     = 4'b1111;
                w_new[0] = mc_state[127:96] ^ round_key[127:96];
                w_new[1] = mc_state[95:64]  ^ round_key[95:64];
                w_new[2] = mc_state[63:32]  ^ round_key[63:32];
                w_new[3] = mc_state[31:0]   ^ round_key[31:0];
            end

            UPD_FINAL: begin
                w_we     = 4'b1111;
                w_new[0] = sr_state[127:96] ^ round_key[127:96];
                w_new[1] = sr_state[95:64]  ^ round_key[95:64];
                w_new[2] = sr_state[63:32]  ^ round_key[63:32];
                w_new[3] = sr_state[31:0]   ^ round_key[31:0];
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
//------------------------------------------------------------------------------
// tb_aes_encipher_block
// Self-checking bench: behavioural S-box and FIPS-197 key memory around the
// DUT, byte-array AES reference model, directed vectors plus random blocks.
//------------------------------------------------------------------------------
module tb_aes_encipher_block;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [16];

    int total  = 0;
    int passed = 0;

    aes_encipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign round_key = rk[round];
    assign new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]],
                        sbox[sboxw[15:8]],  sbox[sboxw[7:0]]};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine transform.
    task automatic build_sbox();
        logic [7:0] inv, b, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv; s = inv ^ 8'h63; r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox[x] = s;
            b = 8'h00;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // FIPS-197 key expansion into the key memory model.
    task automatic expand(input logic [255:0] key, input bit k256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = k256 ? 8 : 4;
        nr = k256 ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // Byte-array AES reference; s[4c+r] is row r of column c.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rnd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    t[4*c+0] = gmul(s[4*c],8'h02) ^ gmul(s[4*c+1],8'h03) ^ s[4*c+2] ^ s[4*c+3];
                    t[4*c+1] = s[4*c] ^ gmul(s[4*c+1],8'h02) ^ gmul(s[4*c+2],8'h03) ^ s[4*c+3];
                    t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2],8'h02) ^ gmul(s[4*c+3],8'h03);
                    t[4*c+3] = gmul(s[4*c],8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3],8'h02);
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Start an op and wait (bounded) for ready; traces round/sboxw while busy.
    task automatic run_op(input bit pulse, input int rst_at, output int lat,
                          output int round_err, output int sbox_err);
        int exp_round;
        bit in_sbox;
        next = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        lat = 0; round_err = 0; sbox_err = 0;
        while (!ready && lat < 200) begin
            exp_round = (lat == 0) ? 0 : ((lat - 1) / 5 + 1);
            if (round !== 4'(exp_round)) round_err++;
            in_sbox = (lat >= 1) && (((lat - 1) % 5) < 4);
            if (!in_sbox && sboxw !== 32'h0) sbox_err++;
            if (lat == rst_at) begin
                reset = 1'b1;
                #1;
                break;
            end
            if (pulse && (lat == 10 || lat == 30)) next = 1'b1;
            @(posedge clk); #1;
            next = 1'b0;
            lat++;
        end
    endtask

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        int lat, rerr, serr, done, gap_bad, wait_cyc;
        logic [255:0] rkey;
        logic [127:0] rpt, rexp;
        bit k256;

        reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_block", new_block, 128'h0);
        check("reset_round", 128'(round), 128'(0));
        check("reset_sboxw", 128'(sboxw), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // AES-128 known answer with round/sboxw trace
        expand(KEY128, 1'b0); keylen = 1'b0; block = PT;
        run_op(1'b0, -1, lat, rerr, serr);
        check("aes128_lat", 128'(lat), 128'(51));
        check("aes128_ct", new_block, CT128);
        check("aes128_model", new_block, aes_ref(PT, 10));
        check("aes128_round_trace", 128'(rerr), 128'(0));
        check("aes128_sboxw_idle", 128'(serr), 128'(0));
        check("aes128_round_hold", 128'(round), 128'(10));
        @(posedge clk); #1;
        check("aes128_ct_hold", new_block, CT128);

        // AES-256 known answer
        expand(KEY256, 1'b1); keylen = 1'b1;
        run_op(1'b0, -1, lat, rerr, serr);
        check("aes256_lat", 128'(lat), 128'(71));
        check("aes256_ct", new_block, CT256);
        check("aes256_round_trace", 128'(rerr), 128'(0));
        check("aes256_sboxw_idle", 128'(serr), 128'(0));

        // next pulses while busy are ignored
        expand(KEY128, 1'b0); keylen = 1'b0;
        run_op(1'b1, -1, lat, rerr, serr);
        check("busy_next_lat", 128'(lat), 128'(51));
        check("busy_next_ct", new_block, CT128);

        // reset mid-operation
        run_op(1'b0, 20, lat, rerr, serr);
        check("midrst_ready", 128'(ready), 128'(1));
        check("midrst_block", new_block, 128'h0);
        check("midrst_round", 128'(round), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, -1, lat, rerr, serr);
        check("postrst_lat", 128'(lat), 128'(51));
        check("postrst_ct", new_block, CT128);

        // next held high: back-to-back ops, one-cycle ready pulses every 52 cycles
        next = 1'b1; done = 0; gap_bad = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                done++;
                check("b2b_ct", new_block, CT128);
                if (k != 52 * done) gap_bad++;
            end
        end
        next = 1'b0;
        check("b2b_count", 128'(done), 128'(3));
        check("b2b_spacing", 128'(gap_bad), 128'(0));
        wait_cyc = 0;
        while (!ready && wait_cyc < 100) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("b2b_drain", 128'(ready), 128'(1));

        // random keys, plaintexts and key lengths against the reference model
        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            k256 = 1'($urandom_range(0, 1));
            expand(rkey, k256);
            keylen = k256; block = rpt;
            rexp = aes_ref(rpt, k256 ? 14 : 10);
            run_op(1'b0, -1, lat, rerr, serr);
            check("rand_lat", 128'(lat), k256 ? 128'(71) : 128'(51));
            check("rand_ct", new_block, rexp);
            check("rand_round_trace", 128'(rerr), 128'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
